// File: rtl/cpu_slot_arbiter_if.sv
// ---------------------------------------------------------------------------
// cpu_slot_arbiter_if
//   Bundles the CPU-side and device-side signals of the time-slot arbiter.
//
//   master : the arbiter itself (drives clock enables, read data, device bus)
//   slave  : the surrounding system (CPU cores and device decoder)
//
//   CPU side    : CH_EN, CH_CE, CH_AD, CH_RD, CH_WR, CH_DO, CH_DI, CH_DV
//                 (channel k occupies bit k / slice [k*AW +: AW] / [k*DW +: DW])
//   Device side : DEV_AD, DEV_RD, DEV_WR, DEV_DI, DEV_DO, DEV_DV, DEV_WAIT,
//                 DEV_CH, DEV_ACT, TIMEOUT
// ---------------------------------------------------------------------------
interface cpu_slot_arbiter_if #(
    parameter int NCH = 3,
    parameter int AW  = 16,
    parameter int DW  = 8
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    // CPU side
    logic [NCH-1:0]    CH_EN;
    logic [NCH-1:0]    CH_CE;
    logic [NCH*AW-1:0] CH_AD;
    logic [NCH-1:0]    CH_RD;
    logic [NCH-1:0]    CH_WR;
    logic [NCH*DW-1:0] CH_DO;
    logic [NCH*DW-1:0] CH_DI;
    logic [NCH-1:0]    CH_DV;

    // Device side
    logic [AW-1:0]     DEV_AD;
    logic              DEV_RD;
    logic              DEV_WR;
    logic [DW-1:0]     DEV_DI;
    logic [DW-1:0]     DEV_DO;
    logic              DEV_DV;
    logic              DEV_WAIT;
    logic [CW-1:0]     DEV_CH;
    logic              DEV_ACT;
    logic              TIMEOUT;

    modport master (
        input  CH_EN, CH_AD, CH_RD, CH_WR, CH_DO,
        input  DEV_DO, DEV_DV, DEV_WAIT,
        output CH_CE, CH_DI, CH_DV,
        output DEV_AD, DEV_RD, DEV_WR, DEV_DI, DEV_CH, DEV_ACT, TIMEOUT
    );

    modport slave (
        output CH_EN, CH_AD, CH_RD, CH_WR, CH_DO,
        output DEV_DO, DEV_DV, DEV_WAIT,
        input  CH_CE, CH_DI, CH_DV,
        input  DEV_AD, DEV_RD, DEV_WR, DEV_DI, DEV_CH, DEV_ACT, TIMEOUT
    );
endinterface

// File: rtl/cpu_slot_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_slot_arbiter
//   Time-slot arbiter letting NCH CPU cores share one I/O device bus.
//   Channels own the bus in round-robin slots of SLOT_LEN MCLK cycles; the
//   device may stretch a slot with DEV_WAIT for up to MAX_WAIT extra cycles,
//   after which the slot is force-ended and TIMEOUT pulses. Each CPU advances
//   only on its one-cycle clock enable (CH_CE) at the end of its own slot.
//   Read data seen at the end of a slot is held per channel until that
//   channel's next slot, so cores see stable data while they are stalled.
//
// Ports
//   MCLK   : master clock, all state on rising edge
//   RESET  : asynchronous, active-high reset
//   bus    : cpu_slot_arbiter_if.master (CPU channels + device bus)
//
// Parameters
//   NCH       : number of CPU channels (1..8)
//   AW, DW    : address / data width
//   SLOT_LEN  : base slot length (>=2)
//   MAX_WAIT  : max stretch cycles per slot (>=1)
//   SKIP_IDLE : 1 = disabled channels lose their slot,
//               0 = their slot still runs with the bus idle
// ---------------------------------------------------------------------------
module cpu_slot_arbiter #(
    parameter int NCH       = 3,
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int SLOT_LEN  = 4,
    parameter int MAX_WAIT  = 15,
    parameter int SKIP_IDLE = 1
) (
    input  logic                MCLK,
    input  logic                RESET,
    cpu_slot_arbiter_if.master  bus
);
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = $clog2(SLOT_LEN);
    localparam int WCW   = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);
    localparam logic [WCW-1:0]   WCNT_MAX = WCW'(MAX_WAIT);
    localparam logic [CW:0]      NCH_W    = (CW+1)'(NCH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SLOT    = 2'd1,
        S_STRETCH = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [CW-1:0]     cur_q, cur_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [DW-1:0]     hold_di_q [NCH];
    logic [DW-1:0]     hold_di_d [NCH];
    logic [NCH-1:0]    hold_dv_q, hold_dv_d;

    // -----------------------------------------------------------------------
    // Candidate search
    //   found_here/idx_here : first candidate starting AT cur (used from IDLE)
    //   found_next/idx_next : first candidate starting AFTER cur, wrapping,
    //                         with cur itself checked last (used at slot end)
    // The loop runs from the farthest offset down to the nearest so the
    // nearest match is the one left standing.
    // -----------------------------------------------------------------------
    logic [NCH-1:0] cand;
    logic           found_here, found_next;
    logic [CW-1:0]  idx_here, idx_next;
    logic [CW:0]    pos_here, pos_next;

    assign cand = (SKIP_IDLE != 0) ? bus.CH_EN : {NCH{1'b1}};

    always_comb begin
        found_here = 1'b0;
        found_next = 1'b0;
        idx_here   = cur_q;
        idx_next   = cur_q;
        pos_here   = '0;
        pos_next   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            // cur + i and cur + i + 1 never reach 2*NCH, so one subtraction wraps
            pos_here = {1'b0, cur_q} + (CW+1)'(i);
            if (pos_here >= NCH_W) begin
                pos_here = pos_here - NCH_W;
            end
            if (cand[pos_here[CW-1:0]]) begin
                found_here = 1'b1;
                idx_here   = pos_here[CW-1:0];
            end

            pos_next = {1'b0, cur_q} + (CW+1)'(i + 1);
            if (pos_next >= NCH_W) begin
                pos_next = pos_next - NCH_W;
            end
            if (cand[pos_next[CW-1:0]]) begin
                found_next = 1'b1;
                idx_next   = pos_next[CW-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Slot status
    // -----------------------------------------------------------------------
    logic owner_on;
    logic end_cycle;
    logic timeout;

    // The owner can lose its enable mid-slot; the slot keeps its timing but
    // the bus, clock enable and capture are suppressed from that cycle on.
    assign owner_on = (state_q != S_IDLE) && bus.CH_EN[cur_q];

    always_comb begin
        end_cycle = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            S_SLOT: begin
                end_cycle = (cnt_q == CNT_LAST) && !bus.DEV_WAIT;
            end
            S_STRETCH: begin
                end_cycle = !bus.DEV_WAIT || (wcnt_q == WCNT_MAX);
                timeout   = bus.DEV_WAIT && (wcnt_q == WCNT_MAX);
            end
            default: begin
                end_cycle = 1'b0;
                timeout   = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        hold_dv_d = hold_dv_q;
        for (int i = 0; i < NCH; i++) begin
            hold_di_d[i] = hold_di_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (found_here) begin
                    state_d = S_SLOT;
                    cur_d   = idx_here;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                end
            end
            S_SLOT: begin
                if (cnt_q == CNT_LAST) begin
                    if (bus.DEV_WAIT) begin
                        state_d = S_STRETCH;
                        wcnt_d  = WCW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STRETCH: begin
                if (!end_cycle) begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Slot hand-over: capture the owner's read result, then pick the
        // next owner (possibly the same channel again).
        if (end_cycle) begin
            if (owner_on) begin
                hold_di_d[cur_q] = bus.DEV_DO;
                hold_dv_d[cur_q] = bus.DEV_DV;
            end
            cnt_d  = '0;
            wcnt_d = '0;
            if (found_next) begin
                state_d = S_SLOT;
                cur_d   = idx_next;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            hold_dv_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                hold_di_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            hold_dv_q <= hold_dv_d;
            for (int i = 0; i < NCH; i++) begin
                hold_di_q[i] <= hold_di_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Device bus: owner's request when the owner is enabled, otherwise idle
    // -----------------------------------------------------------------------
    assign bus.DEV_AD  = owner_on ? bus.CH_AD[cur_q*AW +: AW] : '0;
    assign bus.DEV_DI  = owner_on ? bus.CH_DO[cur_q*DW +: DW] : '0;
    assign bus.DEV_RD  = owner_on && bus.CH_RD[cur_q];
    assign bus.DEV_WR  = owner_on && bus.CH_WR[cur_q];
    assign bus.DEV_CH  = cur_q;
    assign bus.DEV_ACT = owner_on;
    assign bus.TIMEOUT = timeout;

    // -----------------------------------------------------------------------
    // Per-channel outputs. The owning channel sees the device data live so
    // it is already valid at its CE edge; everyone else sees its held copy.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic live;
            assign live = owner_on && (cur_q == CW'(gi));

            assign bus.CH_CE[gi]           = end_cycle && live;
            assign bus.CH_DI[gi*DW +: DW]  = live ? bus.DEV_DO : hold_di_q[gi];
            assign bus.CH_DV[gi]           = live ? bus.DEV_DV : hold_dv_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_cpu_slot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_slot_arbiter
//   Directed bench for cpu_slot_arbiter. Two instances run in lockstep on the
//   same stimulus: dut_a with SKIP_IDLE=1 and dut_b with SKIP_IDLE=0.
//   Cycle n is the MCLK period ending with the n-th rising edge after RESET
//   falls; inputs change 1 time unit after an edge, outputs are sampled 2
//   time units after it.
// ---------------------------------------------------------------------------
module tb_cpu_slot_arbiter;
    localparam int NCH = 3;
    localparam int AW  = 16;
    localparam int DW  = 8;

    logic mclk = 1'b0;
    logic rst  = 1'b1;

    logic [NCH-1:0]    ch_en    = 3'b111;
    logic [NCH*AW-1:0] ch_ad    = {16'h3002, 16'h2001, 16'h1000};
    logic [NCH-1:0]    ch_rd    = 3'b111;
    logic [NCH-1:0]    ch_wr    = 3'b000;
    logic [NCH*DW-1:0] ch_do    = {8'hC2, 8'hB1, 8'hA0};
    logic [DW-1:0]     dev_do   = 8'h00;
    logic              dev_dv   = 1'b0;
    logic              dev_wait = 1'b0;

    logic [15:0] addr_tab [3] = '{16'h1000, 16'h2001, 16'h3002};
    logic [7:0]  do_tab   [3] = '{8'hA0, 8'hB1, 8'hC2};

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 mclk = ~mclk;

    cpu_slot_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus_a ();
    cpu_slot_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus_b ();

    assign bus_a.CH_EN = ch_en;    assign bus_b.CH_EN = ch_en;
    assign bus_a.CH_AD = ch_ad;    assign bus_b.CH_AD = ch_ad;
    assign bus_a.CH_RD = ch_rd;    assign bus_b.CH_RD = ch_rd;
    assign bus_a.CH_WR = ch_wr;    assign bus_b.CH_WR = ch_wr;
    assign bus_a.CH_DO = ch_do;    assign bus_b.CH_DO = ch_do;
    assign bus_a.DEV_DO = dev_do;  assign bus_b.DEV_DO = dev_do;
    assign bus_a.DEV_DV = dev_dv;  assign bus_b.DEV_DV = dev_dv;
    assign bus_a.DEV_WAIT = dev_wait;
    assign bus_b.DEV_WAIT = dev_wait;

    cpu_slot_arbiter #(
        .NCH(NCH), .AW(AW), .DW(DW), .SLOT_LEN(4), .MAX_WAIT(15), .SKIP_IDLE(1)
    ) dut_a (
        .MCLK  (mclk),
        .RESET (rst),
        .bus   (bus_a.master)
    );

    cpu_slot_arbiter #(
        .NCH(NCH), .AW(AW), .DW(DW), .SLOT_LEN(4), .MAX_WAIT(15), .SKIP_IDLE(0)
    ) dut_b (
        .MCLK  (mclk),
        .RESET (rst),
        .bus   (bus_b.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Hold reset for two edges, release 1 unit after an edge: we are then in cycle 1.
    task automatic pulse_reset();
        @(posedge mclk);
        #1 rst = 1'b1;
        repeat (2) @(posedge mclk);
        #1 rst = 1'b0;
    endtask

    // All channels enabled, no wait: 4-cycle slots 0,1,2 starting at cycle 2.
    // With data_on, ch1 returns 5A/valid at its end (cycle 21), then the
    // device data changes and ch1 must keep the held value.
    task automatic run_rr(input int last_c, input bit data_on);
        int       owner;
        bit       last;
        logic [2:0] exp_ce;
        for (int c = 2; c <= last_c; c++) begin
            @(posedge mclk);
            #1;
            if (data_on) begin
                dev_do = (c == 21) ? 8'h5A : ((c > 21) ? 8'h33 : 8'h00);
                dev_dv = (c == 21);
            end
            #1;
            owner  = ((c - 2) / 4) % 3;
            last   = (((c - 2) % 4) == 3);
            exp_ce = last ? (3'b001 << owner) : 3'b000;
            chk($sformatf("rr_ce_c%0d", c), bus_a.CH_CE, exp_ce);
            chk($sformatf("rr_ch_c%0d", c), bus_a.DEV_CH, owner);
            chk($sformatf("rr_ad_c%0d", c), bus_a.DEV_AD, addr_tab[owner]);
            chk($sformatf("rr_di_c%0d", c), bus_a.DEV_DI, do_tab[owner]);
            chk($sformatf("rr_act_c%0d", c), bus_a.DEV_ACT, 1);
            chk($sformatf("rr_rd_c%0d", c), bus_a.DEV_RD, 1);
            chk($sformatf("rr_to_c%0d", c), bus_a.TIMEOUT, 0);
            if (data_on && c >= 21) begin
                chk($sformatf("hold_di1_c%0d", c), bus_a.CH_DI[15:8], 8'h5A);
                chk($sformatf("hold_dv1_c%0d", c), bus_a.CH_DV[1], 1);
            end else if (data_on) begin
                chk($sformatf("pre_dv_c%0d", c), bus_a.CH_DV, 0);
            end
        end
    endtask

    initial begin
        int   ob;
        bit   last;
        logic [2:0] exp_ce;

        // ---------------- reset state ----------------
        repeat (2) @(posedge mclk);
        #2;
        chk("rst_ce",  bus_a.CH_CE, 0);
        chk("rst_act", bus_a.DEV_ACT, 0);
        chk("rst_ch",  bus_a.DEV_CH, 0);
        chk("rst_ad",  bus_a.DEV_AD, 0);
        chk("rst_to",  bus_a.TIMEOUT, 0);
        chk("rst_dv",  bus_a.CH_DV, 0);
        chk("rst_di",  bus_a.CH_DI, 0);
        #1 rst = 1'b0;
        #1;
        chk("c1_idle_act", bus_a.DEV_ACT, 0);

        // ---------------- tests 1 and 2: round robin + held read data ----------
        run_rr(29, 1'b1);

        // ---------------- test 3: 3-cycle stretch of slot 0 ----------------
        dev_do = 8'h00;
        dev_dv = 1'b0;
        pulse_reset();
        for (int c = 2; c <= 12; c++) begin
            @(posedge mclk);
            #1 dev_wait = (c >= 5 && c <= 7);
            #1;
            chk($sformatf("wt_ce_c%0d", c), bus_a.CH_CE,
                (c == 8) ? 3'b001 : ((c == 12) ? 3'b010 : 3'b000));
            chk($sformatf("wt_to_c%0d", c), bus_a.TIMEOUT, 0);
            chk($sformatf("wt_ch_c%0d", c), bus_a.DEV_CH, (c <= 8) ? 0 : 1);
        end

        // ---------------- test 4: stuck wait, 19-cycle slots with timeout -------
        dev_wait = 1'b0;
        pulse_reset();
        dev_wait = 1'b1;
        for (int c = 2; c <= 46; c++) begin
            @(posedge mclk);
            #2;
            chk($sformatf("tmo_to_c%0d", c), bus_a.TIMEOUT, (c == 20 || c == 39) ? 1 : 0);
            chk($sformatf("tmo_ce_c%0d", c), bus_a.CH_CE,
                (c == 20) ? 3'b001 : ((c == 39) ? 3'b010 : 3'b000));
            chk($sformatf("tmo_ch_c%0d", c), bus_a.DEV_CH,
                (c <= 20) ? 0 : ((c <= 39) ? 1 : 2));
        end

        // ---------------- test 6: reset during ch2 stretch ----------------
        chk("pre_rst_act", bus_a.DEV_ACT, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_act", bus_a.DEV_ACT, 0);
        chk("mid_rst_ch",  bus_a.DEV_CH, 0);
        chk("mid_rst_ad",  bus_a.DEV_AD, 0);
        chk("mid_rst_rd",  bus_a.DEV_RD, 0);
        chk("mid_rst_ce",  bus_a.CH_CE, 0);
        chk("mid_rst_to",  bus_a.TIMEOUT, 0);
        repeat (2) @(posedge mclk);
        #1 rst = 1'b0;
        dev_wait = 1'b0;
        run_rr(13, 1'b0);

        // ---------------- test 5: channel 1 disabled ----------------
        ch_en = 3'b101;
        pulse_reset();
        for (int c = 2; c <= 17; c++) begin
            @(posedge mclk);
            #2;
            last   = (((c - 2) % 4) == 3);
            // skip mode: owners alternate 0,2
            ob     = ((((c - 2) / 4) % 2) == 0) ? 0 : 2;
            exp_ce = last ? (3'b001 << ob) : 3'b000;
            chk($sformatf("skip_ch_c%0d", c), bus_a.DEV_CH, ob);
            chk($sformatf("skip_ce_c%0d", c), bus_a.CH_CE, exp_ce);
            chk($sformatf("skip_act_c%0d", c), bus_a.DEV_ACT, 1);
            // no-skip mode: owners 0,1,2 with slot 1 idle
            ob     = ((c - 2) / 4) % 3;
            exp_ce = (last && ob != 1) ? (3'b001 << ob) : 3'b000;
            chk($sformatf("noskip_ch_c%0d", c), bus_b.DEV_CH, ob);
            chk($sformatf("noskip_ce_c%0d", c), bus_b.CH_CE, exp_ce);
            chk($sformatf("noskip_act_c%0d", c), bus_b.DEV_ACT, (ob != 1) ? 1 : 0);
            chk($sformatf("noskip_ad_c%0d", c), bus_b.DEV_AD, (ob != 1) ? addr_tab[ob] : 16'h0);
            chk($sformatf("noskip_rd_c%0d", c), bus_b.DEV_RD, (ob != 1) ? 1 : 0);
        end

        // All channels disabled mid-slot: bus idles at once, skip-mode goes IDLE,
        // no-skip mode keeps timing slots with the bus idle.
        for (int c = 18; c <= 25; c++) begin
            @(posedge mclk);
            #1;
            if (c == 18) ch_en = 3'b000;
            #1;
            chk($sformatf("off_act_a_c%0d", c), bus_a.DEV_ACT, 0);
            chk($sformatf("off_act_b_c%0d", c), bus_b.DEV_ACT, 0);
            chk($sformatf("off_ce_a_c%0d", c), bus_a.CH_CE, 0);
            chk($sformatf("off_ce_b_c%0d", c), bus_b.CH_CE, 0);
            chk($sformatf("off_ad_a_c%0d", c), bus_a.DEV_AD, 0);
            chk($sformatf("off_ch_a_c%0d", c), bus_a.DEV_CH, 0);
            chk($sformatf("off_ch_b_c%0d", c), bus_b.DEV_CH, ((c - 2) / 4) % 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
